// File: rtl/shift_sequencer_pkg.sv
// shift_sequencer_pkg: op codes, FSM state codes and default width shared by the shift sequencer.
package shift_sequencer_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/shift_step.sv
// shift_step: one combinational 1-bit (or 2-bit when two=1) shift/rotate step.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] r,
  input  logic             two,
  output logic [WIDTH-1:0] nxt
);
  logic [WIDTH-1:0] s1, s2;
  always_comb begin
    s1 = op == OP_SLL ? {r[WIDTH-2:0], 1'b0} :
         op == OP_SRL ? {1'b0, r[WIDTH-1:1]} :
         op == OP_SRA ? {r[WIDTH-1], r[WIDTH-1:1]} :
                        {r[0], r[WIDTH-1:1]};
    s2 = op == OP_SLL ? {r[WIDTH-3:0], 2'b00} :
         op == OP_SRL ? {2'b00, r[WIDTH-1:2]} :
         op == OP_SRA ? {{2{r[WIDTH-1]}}, r[WIDTH-1:2]} :
                        {r[1:0], r[WIDTH-1:2]};
    nxt = two ? s2 : s1;
  end
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shift/rotate sequencer (IDLE -> SHIFT -> DONE).
// Define SHIFT_DUAL_STEP_EN to shift two bits per cycle while two or more remain.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [AMT_W-1:0] AMOUNT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef SHIFT_DUAL_STEP_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif
  logic [1:0] state, op_q;
  logic [CW-1:0] count, n, step;
  logic [WIDTH-1:0] nxt;
  logic two;
  // Rotates wrap modulo WIDTH; shifts saturate at WIDTH, which already clears/sign-fills.
  always_comb begin
    n = OP == OP_ROR ? CW'(int'(AMOUNT) % WIDTH) : int'(AMOUNT) >= WIDTH ? CW'(WIDTH) : CW'(AMOUNT);
    two = DUAL && count > CW'(1);
    step = two ? CW'(2) : CW'(1);
    BUSY = state == ST_SHIFT || state == ST_DONE;
    DONE = state == ST_DONE;
  end
  shift_step #(.WIDTH(WIDTH)) u_step (.op(op_q), .r(RESULT), .two(two), .nxt(nxt));
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_IDLE;
      count <= '0;
      op_q <= OP_SLL;
      RESULT <= '0;
    end else if (state == ST_IDLE) begin
      if (START) begin
        op_q <= OP;
        RESULT <= DATA_IN;
        count <= n;
        state <= n == '0 ? ST_DONE : ST_SHIFT;
      end
    end else if (state == ST_SHIFT) begin
      RESULT <= nxt;
      count <= count - step;
      state <= count <= step ? ST_DONE : ST_SHIFT;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vector table plus hand-written corner sequences.
module tb_shift_sequencer;
  import shift_sequencer_pkg::*;
  logic CLK = 0, RESET = 1, START = 0, BUSY, DONE;
  logic [1:0] OP = 0;
  logic [7:0] DATA_IN = 0, AMOUNT = 0, RESULT;
  int checks = 0, errors = 0;
  typedef struct {
    logic [1:0] op;
    logic [7:0] d;
    logic [7:0] a;
    logic [7:0] exp;
    int n;
  } vec_t;
  vec_t v[12];

  shift_sequencer dut (.CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .DATA_IN(DATA_IN),
                       .AMOUNT(AMOUNT), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int n);
`ifdef SHIFT_DUAL_STEP_EN
    return (n + 1) / 2 + 1;
`else
    return n + 1;
`endif
  endfunction

  task automatic run(input logic [1:0] op, input logic [7:0] d, input logic [7:0] a,
                     output int lat, output int busy_cyc, output logic [7:0] res);
    @(negedge CLK);
    OP = op; DATA_IN = d; AMOUNT = a; START = 1;
    lat = 0; busy_cyc = 0;
    do begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      START = 0; OP = ~op; DATA_IN = ~d; AMOUNT = 8'd1;
      if (BUSY) busy_cyc++;
    end while (!DONE && lat < 40);
    res = RESULT;
  endtask

  initial begin
    int lat, bc, pulses;
    logic [7:0] res;
    v[0]  = '{OP_ROR, 8'hB1, 8'd3,   8'h36, 3};
    v[1]  = '{OP_SRA, 8'h90, 8'd12,  8'hFF, 8};
    v[2]  = '{OP_SLL, 8'h90, 8'd12,  8'h00, 8};
    v[3]  = '{OP_ROR, 8'h5A, 8'd8,   8'h5A, 0};
    v[4]  = '{OP_SRL, 8'h80, 8'd7,   8'h01, 7};
    v[5]  = '{OP_SLL, 8'h01, 8'd1,   8'h02, 1};
    v[6]  = '{OP_SRA, 8'h80, 8'd3,   8'hF0, 3};
    v[7]  = '{OP_SRL, 8'hF0, 8'd6,   8'h03, 6};
    v[8]  = '{OP_ROR, 8'h01, 8'd9,   8'h80, 1};
    v[9]  = '{OP_SLL, 8'hA5, 8'd0,   8'hA5, 0};
    v[10] = '{OP_SRA, 8'h7F, 8'd255, 8'h00, 8};
    v[11] = '{OP_ROR, 8'h12, 8'd4,   8'h21, 4};
    #12;
    chk("reset_busy", BUSY, 0);
    chk("reset_done", DONE, 0);
    chk("reset_result", RESULT, 0);
    @(negedge CLK);
    RESET = 0;
    foreach (v[i]) begin
      run(v[i].op, v[i].d, v[i].a, lat, bc, res);
      chk($sformatf("v%0d_result", i), res, v[i].exp);
      chk($sformatf("v%0d_latency", i), lat, lat_of(v[i].n));
      chk($sformatf("v%0d_busy_cycles", i), bc, lat_of(v[i].n));
      @(negedge CLK);
      chk($sformatf("v%0d_done_pulse", i), {BUSY, DONE}, 0);
      chk($sformatf("v%0d_result_hold", i), RESULT, v[i].exp);
    end
    // Second START during a busy ROR must be dropped.
    @(negedge CLK);
    OP = OP_ROR; DATA_IN = 8'hB1; AMOUNT = 8'd3; START = 1;
    @(negedge CLK);
    OP = OP_SLL; DATA_IN = 8'h01; AMOUNT = 8'd1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (k == 1) START = 0;
      if (DONE) pulses++;
    end
    chk("busy_start_pulses", pulses, 1);
    chk("busy_start_result", RESULT, 8'h36);
    // START in the DONE cycle is ignored.
    @(negedge CLK);
    OP = OP_ROR; DATA_IN = 8'h5A; AMOUNT = 8'd8; START = 1;
    @(negedge CLK);
    chk("n0_done", DONE, 1);
    OP = OP_SLL; DATA_IN = 8'h01; AMOUNT = 8'd1;
    @(negedge CLK);
    START = 0;
    chk("done_start_busy", BUSY, 0);
    chk("done_start_result", RESULT, 8'h5A);
    // Asynchronous reset in the middle of an SRL.
    @(negedge CLK);
    OP = OP_SRL; DATA_IN = 8'hF0; AMOUNT = 8'd6; START = 1;
    @(negedge CLK);
    START = 0;
    repeat (2) @(negedge CLK);
`ifdef SHIFT_DUAL_STEP_EN
    chk("mid_result", RESULT, 8'h0F);
`else
    chk("mid_result", RESULT, 8'h3C);
`endif
    #2 RESET = 1;
    #1;
    chk("async_busy", BUSY, 0);
    chk("async_done", DONE, 0);
    chk("async_result", RESULT, 0);
    @(negedge CLK);
    RESET = 0;
    run(OP_SRL, 8'hF0, 8'd6, lat, bc, res);
    chk("post_reset_result", res, 8'h03);
    chk("post_reset_latency", lat, lat_of(6));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
